// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers.
// The winner's byte is latched, strobed once, and the UART is held until TiP falls or the start times out.
module uart_tx_arbiter #(
    parameter int N_REQ         = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     I_REQ,
    input  logic [8*N_REQ-1:0]   I_DATA,
    output logic [N_REQ-1:0]     O_ACK,
    output logic [N_REQ-1:0]     O_GRANT,
    output logic [7:0]           U_DATA,
    output logic                 U_SEND,
    input  logic                 U_TIP,
    output logic                 O_BUSY,
    output logic                 O_TIMEOUT
);
    localparam int LW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_END} state_t;

    state_t           state, state_n;
    logic [LW-1:0]    last, last_n, win, idx;
    logic             hit;
    logic [7:0]       cnt, cnt_n, data_n;
    logic [N_REQ-1:0] grant_n, ack_n, win_oh;
    logic             send_n, tmo_n;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        hit = 1'b0;
        win = last;
        idx = last;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = LW'((int'(last) + k) % N_REQ);
            if (!hit && I_REQ[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    assign win_oh = N_REQ'(1) << win;
    assign O_BUSY = state != IDLE;

    always_comb begin
        state_n = state;
        last_n  = last;
        data_n  = U_DATA;
        grant_n = O_GRANT;
        cnt_n   = cnt;
        send_n  = 1'b0;
        ack_n   = '0;
        tmo_n   = 1'b0;
        case (state)
            IDLE: if (hit) begin
                data_n  = I_DATA[8*win +: 8];
                grant_n = win_oh;
                ack_n   = win_oh;
                last_n  = win;
                send_n  = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                cnt_n   = '0;
                state_n = WAIT_START;
            end
            WAIT_START: if (U_TIP) state_n = WAIT_END;
            else if (cnt == 8'(START_TIMEOUT - 1)) begin
                tmo_n   = 1'b1;
                grant_n = '0;
                cnt_n   = cnt + 8'd1;
                state_n = IDLE;
            end else cnt_n = cnt + 8'd1;
            WAIT_END: if (!U_TIP) begin
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LW'(N_REQ - 1);
            U_DATA    <= 8'h00;
            O_GRANT   <= '0;
            O_ACK     <= '0;
            U_SEND    <= 1'b0;
            O_TIMEOUT <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            U_DATA    <= data_n;
            O_GRANT   <= grant_n;
            O_ACK     <= ack_n;
            U_SEND    <= send_n;
            O_TIMEOUT <= tmo_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized frames against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;
    localparam int N  = 2;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] I_REQ = '0;
    logic [8*N-1:0] I_DATA = '0;
    logic [N-1:0] O_ACK, O_GRANT;
    logic [7:0]   U_DATA;
    logic         U_SEND, U_TIP = 1'b0, O_BUSY, O_TIMEOUT;
    int           checks = 0, errors = 0, last_m = N - 1;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(ST)) dut (
        .clk(clk), .rst(rst), .I_REQ(I_REQ), .I_DATA(I_DATA), .O_ACK(O_ACK),
        .O_GRANT(O_GRANT), .U_DATA(U_DATA), .U_SEND(U_SEND), .U_TIP(U_TIP),
        .O_BUSY(O_BUSY), .O_TIMEOUT(O_TIMEOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First set request at or after last+1, wrapping.
    function automatic int rr(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
        return 0;
    endfunction

    // Called at a negedge with the DUT idle. The UART model raises TiP d cycles after
    // the strobe cycle for len cycles; TiP later than ST cycles means the start is abandoned.
    task automatic frame(input logic [N-1:0] req, input logic [7:0] b0, input logic [7:0] b1,
                         input int d, input int len, input bit hold, input bit swap,
                         input logic [7:0] nb);
        int w, e;
        logic [7:0] byt;
        I_REQ  = req;
        I_DATA = {b1, b0};
        w   = rr(req, last_m);
        byt = (w == 1) ? b1 : b0;
        e   = (d > ST) ? ST + 1 : d + len + 1;
        @(negedge clk);
        U_TIP = (d == 0);
        chk("send", 32'(U_SEND), 1);
        chk("ack", 32'(O_ACK), 1 << w);
        chk("grant", 32'(O_GRANT), 1 << w);
        chk("data", 32'(U_DATA), 32'(byt));
        chk("busy", 32'(O_BUSY), 1);
        chk("timeout_early", 32'(O_TIMEOUT), 0);
        if (!hold) I_REQ = '0;
        for (int k = 1; k <= e; k++) begin
            @(negedge clk);
            U_TIP = (k >= d) && (k < d + len);
            if (swap && k == 1) I_DATA[8*w +: 8] = nb;
            chk("send_once", 32'(U_SEND), 0);
            chk("ack_once", 32'(O_ACK), 0);
            chk("data_hold", 32'(U_DATA), 32'(byt));
            chk("busy_frame", 32'(O_BUSY), 32'(k < e));
            chk("timeout", 32'(O_TIMEOUT), 32'(d > ST && k == e));
            chk("grant_frame", 32'(O_GRANT), (k < e) ? (1 << w) : 0);
        end
        U_TIP  = 1'b0;
        last_m = w;
    endtask

    initial begin
        int w;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_send", 32'(U_SEND), 0);
        chk("rst_ack", 32'(O_ACK), 0);
        chk("rst_grant", 32'(O_GRANT), 0);
        chk("rst_busy", 32'(O_BUSY), 0);
        chk("rst_timeout", 32'(O_TIMEOUT), 0);
        chk("rst_data", 32'(U_DATA), 0);
        // contention: both held, grants rotate from requester 0
        for (int i = 0; i < 4; i++) frame(2'b11, 8'hA0, 8'hB1, 1, 10, 1'b1, 1'b0, 8'h00);
        I_REQ = '0;
        @(negedge clk);
        chk("idle_after_rot", 32'(O_BUSY), 0);
        // single request
        frame(2'b01, 8'h55, 8'h00, 1, 10, 1'b0, 1'b0, 8'h00);
        // requester 1 swaps its byte right after the ack
        frame(2'b10, 8'h00, 8'h77, 2, 10, 1'b0, 1'b1, 8'h3C);
        frame(2'b10, 8'h00, 8'h3C, 2, 10, 1'b0, 1'b0, 8'h00);
        // timeout, then requester 1 next
        frame(2'b01, 8'h11, 8'h22, 1000, 2, 1'b0, 1'b0, 8'h00);
        frame(2'b11, 8'h33, 8'h44, 1, 5, 1'b0, 1'b0, 8'h00);
        // late TiP and the boundary on either side of the timeout
        frame(2'b01, 8'h5A, 8'hA5, 3, 6, 1'b0, 1'b0, 8'h00);
        frame(2'b01, 8'h5B, 8'hA5, ST, 6, 1'b0, 1'b0, 8'h00);
        frame(2'b01, 8'h5C, 8'hA5, ST + 1, 6, 1'b0, 1'b0, 8'h00);
        frame(2'b10, 8'h5C, 8'hA6, 0, 3, 1'b0, 1'b0, 8'h00);
        // reset during WAIT_END
        I_REQ  = 2'b11;
        I_DATA = {8'hB1, 8'hA0};
        w = rr(2'b11, last_m);
        @(negedge clk);
        U_TIP = 1'b1;
        chk("pre_rst_send", 32'(U_SEND), 1);
        chk("pre_rst_ack", 32'(O_ACK), 1 << w);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(O_BUSY), 1);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        U_TIP = 1'b0;
        chk("mid_rst_send", 32'(U_SEND), 0);
        chk("mid_rst_ack", 32'(O_ACK), 0);
        chk("mid_rst_grant", 32'(O_GRANT), 0);
        chk("mid_rst_busy", 32'(O_BUSY), 0);
        chk("mid_rst_timeout", 32'(O_TIMEOUT), 0);
        chk("mid_rst_data", 32'(U_DATA), 0);
        last_m = N - 1;
        frame(2'b11, 8'hC0, 8'hC1, 1, 4, 1'b0, 1'b0, 8'h00);
        // randomized frames
        for (int i = 0; i < 30; i++)
            frame(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, ST + 2)), int'($urandom_range(2, 12)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        I_REQ = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_send", 32'(U_SEND), 0);
            chk("idle_busy", 32'(O_BUSY), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single `UART` transmitter among `N_REQ` byte producers (ULPI packet parser, status/debug reporter, …) in the USB3300 parser. It latches the winning requester's byte, drives the UART `data`/`send_data` inputs, and tracks the UART `TiP` (transmission in progress) output. It releases the transmitter only after the frame has fully left `Tx`. A start timeout prevents lock-up if the UART never acknowledges.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, legal 2..4.
- `START_TIMEOUT`, 16: cycles allowed after `U_SEND` for `U_TIP` to rise, legal 2..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `I_REQ`  in  N_REQ  per-requester byte-ready level; bit i = requester i.
- `I_DATA`  in  8*N_REQ  packed bytes; requester i in bits [8i+7:8i].
- `O_ACK`  out  N_REQ  one-cycle pulse: requester i's byte was captured.
- `O_GRANT`  out  N_REQ  one-hot; requester owning the UART for the current frame, else 0.
- `U_DATA`  out  8  byte to UART `data` input.
- `U_SEND`  out  1  one-cycle start strobe to UART `send_data`.
- `U_TIP`  in  1  UART `TiP` output.
- `O_BUSY`  out  1  high whenever state ≠ IDLE.
- `O_TIMEOUT`  out  1  one-cycle pulse: a frame start was abandoned.

## Operation
- States: IDLE, SEND, WAIT_START, WAIT_END.
- IDLE:
  - If any `I_REQ` bit is set, pick the winner by round-robin. The search starts at `last+1` (mod `N_REQ`) and the first set bit wins.
  - On the clock edge: capture `I_DATA` of the winner into `U_DATA`, set `O_GRANT` one-hot, set `last` = winner, go to SEND.
  - If no request, stay in IDLE.
- SEND (exactly 1 cycle):
  - `U_SEND`=1, `O_ACK[winner]`=1.
  - Clear the timeout counter and go to WAIT_START.
- WAIT_START:
  - If `U_TIP`=1, go to WAIT_END.
  - Otherwise increment the counter. When the counter reaches `START_TIMEOUT`, pulse `O_TIMEOUT`, clear `O_GRANT`, and go to IDLE. The byte is dropped, not retried.
- WAIT_END:
  - When `U_TIP`=0, clear `O_GRANT` and go to IDLE.
  - There is no timeout in this state; frame length is the UART's responsibility.
- Requester contract:
  - Hold `I_REQ` and `I_DATA` stable until `O_ACK` is seen.
  - After `O_ACK`, the requester may change `I_DATA` or drop `I_REQ` immediately; the arbiter's copy of the byte is already latched.
  - A requester that keeps `I_REQ` high after `O_ACK` is treated as presenting its next byte.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N_REQ-1,0,…. No requester waits more than N_REQ-1 frames.
- `I_REQ` changes while the arbiter is not in IDLE are ignored until it returns to IDLE.
- `U_DATA` holds its last captured value; it changes only on a grant.

## Timing
- Reset (on `rst`=1 at a clock edge, in any state, including mid-frame):
  - state=IDLE; `U_SEND`=0, `O_ACK`=0, `O_GRANT`=0, `O_TIMEOUT`=0, `O_BUSY`=0; `U_DATA`=8'h00; timeout counter=0.
  - `last`=N_REQ-1, so requester 0 has priority first.
  - A frame already in flight inside the UART is not aborted. The arbiter must not strobe again until it re-arbitrates from IDLE.
- Grant latency: `I_REQ` sampled high in IDLE at edge n → `U_SEND`, `O_ACK`, and valid `U_DATA` during cycle n+1 (registered outputs).
- `U_SEND` and `O_ACK` are high for exactly one cycle per granted byte and are coincident.
- `U_TIP` rising in the SEND cycle itself is not seen; it is seen in the first WAIT_START cycle, with 0 timeout cycles used.
- Timeout: `O_TIMEOUT` pulses in the cycle after the START_TIMEOUT-th consecutive WAIT_START cycle with `U_TIP`=0. `O_BUSY` drops in that same cycle.
- Frame end: `U_TIP` sampled 0 in WAIT_END at edge m → IDLE at m+1. The earliest next `U_SEND` is at m+2.
- `O_BUSY` is combinational from state; all other outputs are registered.

## Test plan
- Single request: after reset, `I_REQ`=2'b01, `I_DATA`[7:0]=8'h55, UART with BAUD_DIVIDER=1.
  - Required: `U_SEND`/`O_ACK[0]` one cycle after the request; `U_DATA`=8'h55.
  - `Tx` shows the frame 0,1,0,1,0,1,0,1,0,1.
  - `O_BUSY` falls one cycle after `TiP` falls.
- Contention and rotation: `I_REQ`=2'b11 held high, bytes 8'hA0/8'hB1.
  - Required: grants alternate 0,1,0,1 over 4 frames; each `U_SEND` is preceded by `TiP`=0 for ≥1 cycle.
- Requester change after ack: requester 1 swaps `I_DATA` to 8'h3C in the cycle after `O_ACK`.
  - Required: the in-flight frame still carries the original byte; the next grant to requester 1 sends 8'h3C.
- Timeout: `U_TIP` tied to 0, START_TIMEOUT=4, request from requester 0.
  - Required: `O_TIMEOUT` pulses exactly 5 cycles after `U_SEND`; state returns to IDLE.
  - Requester 1 is granted next if requesting.
- Reset mid-frame: assert `rst` for 1 cycle during WAIT_END.
  - Required: all outputs at reset values on the next cycle; `last`=N_REQ-1; with both requesting, requester 0 is granted first after reset.
- Late TiP: `U_TIP` rises 3 cycles after `U_SEND` with START_TIMEOUT=16.
  - Required: no `O_TIMEOUT`; single grant completes normally.
